// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the 8-bit accumulator microprocessor.
// Sequences FETCH -> DECODE -> (MEM -> (EXEC)) over the shared datapath and
// handles variable-latency memory through a ready handshake with a timeout fault.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   run               permits a new instruction fetch (sampled only in FETCH)
//   ir_opcode         IR opcode field
//   zero_flag         ACC == 0
//   mem_ready         memory completes the current request this cycle
//   mem_rd, mem_wr    memory request strobes
//   addr_sel          0 = PC address, 1 = IR operand address
//   ir_load, pc_inc, pc_load, acc_load, disp_load   datapath strobes
//   alu_op            0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR
//   halted, fault     terminal status
//   illegal           one-cycle pulse on an undefined opcode in DECODE
//   instr_count       retired-instruction count (wraps)
module cpu_ctrl_fsm #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [3:0]       ir_opcode,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             acc_load,
  output logic [2:0]       alu_op,
  output logic             disp_load,
  output logic             halted,
  output logic             fault,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    StFetch, StDecode, StMem, StExec, StHalt, StFault
  } state_e;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpSta = 4'h2;
  localparam logic [3:0] OpAdd = 4'h3;
  localparam logic [3:0] OpSub = 4'h4;
  localparam logic [3:0] OpAnd = 4'h5;
  localparam logic [3:0] OpOr  = 4'h6;
  localparam logic [3:0] OpJmp = 4'h7;
  localparam logic [3:0] OpJz  = 4'h8;
  localparam logic [3:0] OpOut = 4'h9;
  localparam logic [3:0] OpHlt = 4'hF;

  // Count value held on the last tolerated wait cycle; one more miss faults.
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StFetch;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    count_d   = count_q;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    addr_sel  = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    acc_load  = 1'b0;
    alu_op    = 3'd0;
    disp_load = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    illegal   = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (run) begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
            wait_d  = '0;
            state_d = StDecode;
          end else if (wait_q == WaitLast) begin
            wait_d  = '0;
            state_d = StFault;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end

      StDecode: begin
        wait_d  = '0;
        state_d = StFetch;
        count_d = count_q + CNT_W'(1);
        case (ir_opcode)
          OpLda, OpSta, OpAdd, OpSub, OpAnd, OpOr: begin
            state_d = StMem;
            count_d = count_q;  // retires later, on leaving MEM/EXEC
          end
          OpJmp: pc_load   = 1'b1;
          OpJz:  pc_load   = zero_flag;
          OpOut: disp_load = 1'b1;
          OpNop: ;
          OpHlt: state_d   = StHalt;
          default: illegal = 1'b1;
        endcase
      end

      StMem: begin
        addr_sel = 1'b1;
        if (ir_opcode == OpSta) mem_wr = 1'b1;
        else                    mem_rd = 1'b1;
        if (mem_ready) begin
          wait_d = '0;
          if (ir_opcode == OpSta) begin
            state_d = StFetch;
            count_d = count_q + CNT_W'(1);
          end else begin
            state_d = StExec;
          end
        end else if (wait_q == WaitLast) begin
          wait_d  = '0;
          state_d = StFault;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      StExec: begin
        acc_load = 1'b1;
        case (ir_opcode)
          OpAdd:   alu_op = 3'd1;
          OpSub:   alu_op = 3'd2;
          OpAnd:   alu_op = 3'd3;
          OpOr:    alu_op = 3'd4;
          default: alu_op = 3'd0;
        endcase
        wait_d  = '0;
        state_d = StFetch;
        count_d = count_q + CNT_W'(1);
      end

      StHalt: halted = 1'b1;

      StFault: begin
        halted = 1'b1;
        fault  = 1'b1;
      end

      default: state_d = StFetch;
    endcase
  end

  assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: a small datapath and latency-programmable memory are
// driven by the controller's strobes; results are compared against an
// instruction-level interpreter of the ISA.
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [3:0]  ir_opcode;
  logic        zero_flag;
  logic        mem_ready;
  logic        mem_rd, mem_wr, addr_sel, ir_load, pc_inc, pc_load, acc_load;
  logic [2:0]  alu_op;
  logic        disp_load, halted, fault, illegal;
  logic [15:0] instr_count;

  logic        mem_rd4, mem_wr4, addr_sel4, ir_load4, pc_inc4, pc_load4, acc_load4;
  logic [2:0]  alu_op4;
  logic        disp_load4, halted4, fault4, illegal4;
  logic [3:0]  instr_count4;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .ir_opcode(ir_opcode), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .acc_load(acc_load),
    .alu_op(alu_op), .disp_load(disp_load), .halted(halted), .fault(fault),
    .illegal(illegal), .instr_count(instr_count)
  );

  // Narrow-counter twin fed the same inputs; only its count width differs.
  cpu_ctrl_fsm #(.TIMEOUT(15), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .run(run), .ir_opcode(ir_opcode), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .mem_rd(mem_rd4), .mem_wr(mem_wr4), .addr_sel(addr_sel4),
    .ir_load(ir_load4), .pc_inc(pc_inc4), .pc_load(pc_load4), .acc_load(acc_load4),
    .alu_op(alu_op4), .disp_load(disp_load4), .halted(halted4), .fault(fault4),
    .illegal(illegal4), .instr_count(instr_count4)
  );

  // Datapath and memory environment.
  logic [7:0] img [16];
  logic [7:0] mem [16];
  logic [7:0] ir, acc, mdr, disp;
  logic [3:0] pc, addr;
  logic [7:0] lat_cnt;
  logic [7:0] lat_sel = 8'd0;
  logic       never_data = 1'b0;

  assign addr      = addr_sel ? ir[3:0] : pc;
  assign ir_opcode = ir[7:4];
  assign zero_flag = (acc == 8'd0);
  assign mem_ready = (mem_rd | mem_wr) && (lat_cnt == lat_sel) && !(never_data && addr_sel);

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= img[i];
      pc <= 4'd0; ir <= 8'd0; acc <= 8'd0; mdr <= 8'd0; disp <= 8'd0; lat_cnt <= 8'd0;
    end else begin
      lat_cnt <= ((mem_rd || mem_wr) && !mem_ready) ? lat_cnt + 8'd1 : 8'd0;
      if (ir_load) ir <= mem[addr];
      if (pc_inc) pc <= pc + 4'd1;
      if (pc_load) pc <= ir[3:0];
      if (mem_rd && mem_ready && addr_sel) mdr <= mem[addr];
      if (mem_wr && mem_ready) mem[addr] <= acc;
      if (acc_load) begin
        case (alu_op)
          3'd0: acc <= mdr;
          3'd1: acc <= acc + mdr;
          3'd2: acc <= acc - mdr;
          3'd3: acc <= acc & mdr;
          3'd4: acc <= acc | mdr;
          default: acc <= acc;
        endcase
      end
      if (disp_load) disp <= acc;
    end
  end

  int wr_cycles = 0, wr_addr_cycles = 0, ill_cycles = 0;
  always @(negedge clk) begin
    if (mem_wr) wr_cycles <= wr_cycles + 1;
    if (mem_wr && addr_sel) wr_addr_cycles <= wr_addr_cycles + 1;
    if (illegal) ill_cycles <= ill_cycles + 1;
  end

  // Instruction-level reference model.
  int         m_cycles, m_count, m_ill;
  logic [7:0] m_acc, m_disp;
  logic [3:0] m_pc;
  bit         m_halted;

  function automatic void model(input int lat, input int maxn);
    logic [7:0] m [16];
    logic [7:0] ins;
    logic [3:0] a;
    m = img;
    m_acc = 8'd0; m_disp = 8'd0; m_pc = 4'd0;
    m_count = 0; m_cycles = 0; m_ill = 0; m_halted = 1'b0;
    for (int n = 0; n < maxn && !m_halted; n++) begin
      ins = m[m_pc];
      a = ins[3:0];
      m_pc = m_pc + 4'd1;
      m_cycles += lat + 2;  // fetch access plus decode
      case (ins[7:4])
        4'h1: begin m_acc = m[a];          m_cycles += lat + 2; end
        4'h2: begin m[a] = m_acc;          m_cycles += lat + 1; end
        4'h3: begin m_acc = m_acc + m[a];  m_cycles += lat + 2; end
        4'h4: begin m_acc = m_acc - m[a];  m_cycles += lat + 2; end
        4'h5: begin m_acc = m_acc & m[a];  m_cycles += lat + 2; end
        4'h6: begin m_acc = m_acc | m[a];  m_cycles += lat + 2; end
        4'h7: m_pc = a;
        4'h8: if (m_acc == 8'd0) m_pc = a;
        4'h9: m_disp = m_acc;
        4'hF: m_halted = 1'b1;
        4'hA, 4'hB, 4'hC, 4'hD, 4'hE: m_ill++;
        default: ;
      endcase
      m_count++;
    end
  endfunction

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic run_check(input logic [7:0] lat, input int maxn, input bit stall);
    int ill0;
    model(int'(lat), maxn);
    lat_sel = lat;
    never_data = 1'b0;
    reset = 1'b0;
    run = 1'b0;
    tick();
    tick();
    chk("rst_count", 32'(instr_count), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    reset = 1'b1;
    if (stall) begin
      repeat (5) begin
        tick();
        chk("stall_mem_rd", 32'(mem_rd), 0);
        chk("stall_count", 32'(instr_count), 0);
      end
    end
    run = 1'b1;
    ill0 = ill_cycles;
    repeat (m_cycles - 1) tick();
    chk("pre_end_halted", 32'(halted), 0);
    tick();
    chk("end_halted", 32'(halted), 32'(m_halted));
    chk("end_fault", 32'(fault), 0);
    chk("end_count", 32'(instr_count), m_count);
    chk("end_count4", 32'(instr_count4), m_count % 16);
    chk("end_acc", 32'(acc), 32'(m_acc));
    chk("end_disp", 32'(disp), 32'(m_disp));
    chk("end_pc", 32'(pc), 32'(m_pc));
    chk("end_illegal", ill_cycles - ill0, m_ill);
  endtask

  initial begin
    int w0, wa0, i0;
    for (int i = 0; i < 16; i++) img[i] = 8'h00;

    // Demo program: LDA 5; ADD 6; OUT; HLT.
    img[0] = 8'h15; img[1] = 8'h36; img[2] = 8'h90; img[3] = 8'hF0;
    img[5] = 8'h03; img[6] = 8'h04;
    run_check(8'd0, 20, 1'b0);
    chk("demo_disp", 32'(disp), 7);
    chk("demo_count", 32'(instr_count), 4);
    // Reset from HALT.
    reset = 1'b0;
    tick();
    chk("halt_rst_halted", 32'(halted), 0);
    chk("halt_rst_count", 32'(instr_count), 0);
    chk("halt_rst_addr", 32'(addr_sel), 0);

    // STA with three wait cycles.
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    img[0] = 8'h1C; img[1] = 8'h2A; img[2] = 8'hF0; img[12] = 8'h5A;
    w0 = wr_cycles;
    wa0 = wr_addr_cycles;
    run_check(8'd3, 10, 1'b0);
    chk("sta_wr_cycles", wr_cycles - w0, 4);
    chk("sta_wr_addr", wr_addr_cycles - wa0, 4);
    chk("sta_mem", 32'(mem[10]), 32'h5A);

    // STA whose write never completes.
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    img[0] = 8'h2A;
    lat_sel = 8'd0;
    never_data = 1'b1;
    do_reset();
    run = 1'b1;
    repeat (16) tick();
    chk("to_before_fault", 32'(fault), 0);
    chk("to_before_wr", 32'(mem_wr), 1);
    chk("to_before_addr", 32'(addr_sel), 1);
    tick();
    chk("to_fault", 32'(fault), 1);
    chk("to_halted", 32'(halted), 1);
    chk("to_wr", 32'(mem_wr), 0);
    chk("to_rd", 32'(mem_rd), 0);
    chk("to_count", 32'(instr_count), 0);
    repeat (3) tick();
    chk("to_sticky", 32'(fault), 1);

    // Reset in the middle of a MEM wait.
    img[0] = 8'h00; img[1] = 8'h1A;
    do_reset();
    run = 1'b1;
    repeat (12) tick();
    chk("memwait_rd", 32'(mem_rd), 1);
    chk("memwait_addr", 32'(addr_sel), 1);
    chk("memwait_count", 32'(instr_count), 1);
    reset = 1'b0;
    tick();
    chk("memwait_rst_addr", 32'(addr_sel), 0);
    chk("memwait_rst_rd", 32'(mem_rd), 1);
    chk("memwait_rst_count", 32'(instr_count), 0);
    chk("memwait_rst_fault", 32'(fault), 0);
    never_data = 1'b0;

    // JZ taken, JZ not taken, JMP.
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    img[0] = 8'h85;
    do_reset();
    run = 1'b1;
    tick();
    chk("jz_taken_pc_load", 32'(pc_load), 1);
    tick();
    chk("jz_taken_pc", 32'(pc), 5);
    img[0] = 8'h1F; img[1] = 8'h85; img[15] = 8'h01;
    do_reset();
    run = 1'b1;
    repeat (5) tick();
    chk("jz_not_pc_load", 32'(pc_load), 0);
    tick();
    chk("jz_not_pc", 32'(pc), 2);
    img[0] = 8'h79;
    do_reset();
    run = 1'b1;
    tick();
    chk("jmp_pc_load", 32'(pc_load), 1);
    tick();
    chk("jmp_pc", 32'(pc), 9);

    // Undefined opcode 0xB behaves as NOP.
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    img[0] = 8'hB0; img[1] = 8'hF0;
    i0 = ill_cycles;
    run_check(8'd0, 10, 1'b0);
    chk("ill_pulses", ill_cycles - i0, 1);
    chk("ill_count", 32'(instr_count), 2);

    // 17 NOPs wrap the 4-bit counter.
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    run_check(8'd0, 17, 1'b1);
    chk("wrap_count4", 32'(instr_count4), 1);

    // Random programs and latencies.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
      run_check(8'($urandom_range(0, 3)), 30, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
